// File: rtl/cu_v2_pkg.sv
// Shared types and decode helpers for the cu_v2 accumulator control unit.
package cu_v2_pkg;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [3:0] {
    ST_START      = 4'd0,
    ST_FETCH_OP   = 4'd1,
    ST_DECODE     = 4'd2,
    ST_FETCH_OPND = 4'd3,
    ST_EXEC_IMPL  = 4'd4,
    ST_EXEC_IMM   = 4'd5,
    ST_EXEC_RD    = 4'd6,
    ST_EXEC_RD_WB = 4'd7,
    ST_EXEC_ST    = 4'd8,
    ST_EXEC_BR    = 4'd9,
    ST_HALT       = 4'd10
  } state_e;

  // Instruction classes: implied, immediate, read, store, branch, halt, illegal.
  typedef enum logic [2:0] {
    CLS_IMPL = 3'd0,
    CLS_IMM  = 3'd1,
    CLS_RD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_HLT  = 3'd5,
    CLS_ILL  = 3'd6
  } opclass_e;

  // Opcodes with control-unit significance.
  localparam logic [7:0] OP_STORE = 8'h03;
  localparam logic [7:0] OP_JMP   = 8'h10;
  localparam logic [7:0] OP_JN    = 8'h11;
  localparam logic [7:0] OP_JP    = 8'h12;
  localparam logic [7:0] OP_JZ    = 8'h13;
  localparam logic [7:0] OP_JNZ   = 8'h14;
  localparam logic [7:0] OP_JC    = 8'h15;
  localparam logic [7:0] OP_HALT  = 8'h1F;

  // Map an opcode byte to its instruction class.
  function automatic opclass_e decode_class(input logic [7:0] op);
    opclass_e cls;
    case (op)
      8'h00, 8'h04:                             cls = CLS_IMPL;
      8'h02, 8'h06, 8'h08, 8'h0E, 8'h0F:        cls = CLS_IMM;
      8'h01, 8'h05, 8'h07, 8'h09,
      8'h0A, 8'h0B, 8'h0C, 8'h0D:               cls = CLS_RD;
      OP_STORE:                                 cls = CLS_ST;
      OP_JMP, OP_JN, OP_JP, OP_JZ, OP_JNZ, OP_JC: cls = CLS_BR;
      OP_HALT:                                  cls = CLS_HLT;
      default:                                  cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  // Execute state reached once all operand bytes of a class are in.
  function automatic state_e class_target(input opclass_e cls);
    state_e s;
    case (cls)
      CLS_IMM: s = ST_EXEC_IMM;
      CLS_RD:  s = ST_EXEC_RD;
      CLS_ST:  s = ST_EXEC_ST;
      CLS_BR:  s = ST_EXEC_BR;
      default: s = ST_HALT;
    endcase
    return s;
  endfunction

  // Branch condition evaluated from the accumulator/ALU flags.
  function automatic logic branch_taken(input logic [7:0] op, input logic z,
                                        input logic n, input logic c);
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JN:   t = n;
      OP_JP:   t = z & ~n;
      OP_JZ:   t = z;
      OP_JNZ:  t = ~z;
      OP_JC:   t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // States that hold mem_req and wait for mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH_OP) || (s == ST_FETCH_OPND) ||
           (s == ST_EXEC_RD)  || (s == ST_EXEC_ST);
  endfunction

endpackage

// File: rtl/cu_mem_watchdog.sv
// Bus-timeout watchdog: counts consecutive not-ready cycles of one memory
// access and flags expiry on the TIMEOUT-th such cycle. TIMEOUT=0 disables it.
module cu_mem_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_en,
  input  logic mem_ready,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is combinational so a same-cycle mem_ready can still win.
    assign expire = wait_en && !mem_ready && (cnt_q == LAST);

    // Next count: restart on clear, advance on each unanswered wait cycle.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (wait_en && !mem_ready && !expire) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/cu_v2.sv
// cu_v2: fetch/decode/execute sequencer for the 8-bit accumulator processor,
// using a mem_req/mem_ready handshake with a bus-timeout watchdog.
//
// Handshake: mem_req is high for every cycle of an access; the access
// completes on the cycle mem_ready is high while mem_req is high (pulses
// for that access are issued combinationally in that same cycle). mem_ready
// is ignored whenever mem_req is low.
module cu_v2
  import cu_v2_pkg::*;
#(
  parameter int unsigned OPND_BYTES   = 1,
  parameter int unsigned TIMEOUT      = 15,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            opcode,
  input  logic                  zflag,
  input  logic                  nflag,
  input  logic                  cflag,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  fetch,
  output logic                  store_mem,
  output logic                  incr_pc,
  output logic                  load_pc,
  output logic                  load_ac,
  output logic [OPND_BYTES:0]   load_ir,
  output logic                  halted,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [3:0]            state
);

  localparam int          LIR_W    = OPND_BYTES + 1;
  localparam logic [1:0]  LAST_IDX = 2'(OPND_BYTES);

  state_e     state_q, state_d;
  opclass_e   cls_q, cls_d;
  logic [1:0] idx_q, idx_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  logic wait_en;
  logic wd_clear;
  logic expire;

  // The watchdog runs only in states that hold an access open; any
  // completed access or non-waiting state restarts its count.
  assign wait_en  = is_wait_state(state_q);
  assign wd_clear = !wait_en || mem_ready;

  cu_mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .wait_en   (wait_en),
    .mem_ready (mem_ready),
    .expire    (expire)
  );

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  // Next-state and output decode; every output defaults to idle first.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    idx_d     = idx_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    fetch     = 1'b1;
    store_mem = 1'b0;
    incr_pc   = 1'b0;
    load_pc   = 1'b0;
    load_ac   = 1'b0;
    load_ir   = '0;
    halted    = 1'b0;

    case (state_q)
      ST_START: begin
        state_d = ST_FETCH_OP;
      end

      ST_FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          load_ir = LIR_W'(1);
          incr_pc = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        cls_d = decode_class(opcode);
        idx_d = 2'd1;
        case (decode_class(opcode))
          CLS_IMPL: state_d = ST_EXEC_IMPL;
          CLS_HLT:  state_d = ST_HALT;
          CLS_ILL: begin
            illegal_d = 1'b1;
            state_d   = TRAP_ILLEGAL ? ST_HALT : ST_FETCH_OP;
          end
          default:  state_d = ST_FETCH_OPND;
        endcase
      end

      ST_FETCH_OPND: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          load_ir = LIR_W'(1) << idx_q;
          incr_pc = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = class_target(cls_q);
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ST_EXEC_IMPL, ST_EXEC_IMM: begin
        load_ac = 1'b1;
        state_d = ST_FETCH_OP;
      end

      ST_EXEC_RD: begin
        mem_req = 1'b1;
        fetch   = 1'b0;
        if (mem_ready) begin
          state_d = ST_EXEC_RD_WB;
        end
      end

      ST_EXEC_RD_WB: begin
        fetch   = 1'b0;
        load_ac = 1'b1;
        state_d = ST_FETCH_OP;
      end

      ST_EXEC_ST: begin
        mem_req   = 1'b1;
        fetch     = 1'b0;
        store_mem = 1'b1;
        if (mem_ready) begin
          state_d = ST_FETCH_OP;
        end
      end

      ST_EXEC_BR: begin
        load_pc = branch_taken(opcode, zflag, nflag, cflag);
        state_d = ST_FETCH_OP;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_START;
      end
    endcase

    // A stalled access abandons the instruction; expire is already
    // suppressed when mem_ready arrives on the same cycle.
    if (expire) begin
      bus_err_d = 1'b1;
      state_d   = ST_HALT;
    end
  end

  // State, operand index, latched class and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_START;
      cls_q     <= CLS_IMPL;
      idx_q     <= 2'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      idx_q     <= idx_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_cu_v2.sv
// Testbench for cu_v2: instruction-level reference model emits the expected
// per-cycle output vector into a queue; a negedge monitor pops and compares.
// Two instances differ only in TRAP_ILLEGAL; the idle one is held in reset.
module tb_cu_v2;

  localparam int OPND = 2;
  localparam int TO   = 4;
  localparam int W    = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel;
  logic rst_a, rst_b;
  assign rst_a = sel ? 1'b1 : rst;
  assign rst_b = sel ? rst  : 1'b1;

  logic [7:0] opcode;
  logic       zflag, nflag, cflag, mem_ready;

  logic a_mem_req, a_fetch, a_store_mem, a_incr_pc, a_load_pc, a_load_ac;
  logic a_halted, a_illegal, a_bus_err;
  logic [OPND:0] a_load_ir;
  logic [3:0] a_state;
  logic b_mem_req, b_fetch, b_store_mem, b_incr_pc, b_load_pc, b_load_ac;
  logic b_halted, b_illegal, b_bus_err;
  logic [OPND:0] b_load_ir;
  logic [3:0] b_state;

  cu_v2 #(.OPND_BYTES(OPND), .TIMEOUT(TO), .TRAP_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode), .zflag(zflag), .nflag(nflag),
    .cflag(cflag), .mem_ready(mem_ready), .mem_req(a_mem_req), .fetch(a_fetch),
    .store_mem(a_store_mem), .incr_pc(a_incr_pc), .load_pc(a_load_pc),
    .load_ac(a_load_ac), .load_ir(a_load_ir), .halted(a_halted),
    .illegal(a_illegal), .bus_err(a_bus_err), .state(a_state)
  );

  cu_v2 #(.OPND_BYTES(OPND), .TIMEOUT(TO), .TRAP_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode), .zflag(zflag), .nflag(nflag),
    .cflag(cflag), .mem_ready(mem_ready), .mem_req(b_mem_req), .fetch(b_fetch),
    .store_mem(b_store_mem), .incr_pc(b_incr_pc), .load_pc(b_load_pc),
    .load_ac(b_load_ac), .load_ir(b_load_ir), .halted(b_halted),
    .illegal(b_illegal), .bus_err(b_bus_err), .state(b_state)
  );

  logic [W-1:0] va, vb;
  assign va = {a_mem_req, a_fetch, a_store_mem, a_incr_pc, a_load_pc, a_load_ac,
               a_load_ir, a_halted, a_illegal, a_bus_err};
  assign vb = {b_mem_req, b_fetch, b_store_mem, b_incr_pc, b_load_pc, b_load_ac,
               b_load_ir, b_halted, b_illegal, b_bus_err};

  // ---------------- reference model state ----------------
  logic [W-1:0] exp_q[$];
  int           w_plan[$];
  bit           ill_m, berr_m, halt_m;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] mk(input logic mreq, input logic ftch,
      input logic st, input logic inc, input logic lpc, input logic lac,
      input logic [2:0] lir, input logic hlt);
    return {mreq, ftch, st, inc, lpc, lac, lir, hlt, ill_m, berr_m};
  endfunction

  function automatic int cls_of(input logic [7:0] op);
    if (op == 8'h00 || op == 8'h04) return 1;
    if (op inside {8'h02, 8'h06, 8'h08, 8'h0E, 8'h0F}) return 2;
    if (op inside {8'h01, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D}) return 3;
    if (op == 8'h03) return 4;
    if (op >= 8'h10 && op <= 8'h15) return 5;
    if (op == 8'h1F) return 6;
    return 0;
  endfunction

  function automatic logic br_of(input logic [7:0] op, input logic z,
                                 input logic n, input logic c);
    if (op == 8'h10) return 1'b1;
    if (op == 8'h11) return n;
    if (op == 8'h12) return z && !n;
    if (op == 8'h13) return z;
    if (op == 8'h14) return !z;
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int next_w();
    if (w_plan.size() > 0) return w_plan.pop_front();
    return $urandom_range(0, 2);
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: apply mem_ready, record the expected outputs.
  task automatic step(input logic mr, input logic [W-1:0] v);
    mem_ready = mr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  // One memory access: kind 0 = PC fetch into IR byte bi, 1 = read, 2 = store.
  task automatic access(input int kind, input int bi, input int w, output bit ok);
    logic       ftch, st;
    logic [2:0] lir;
    ftch = (kind == 0);
    st   = (kind == 2);
    lir  = (kind == 0) ? 3'(1 << bi) : 3'b000;
    ok   = 1'b1;
    for (int i = 0; i < w; i++) begin
      step(1'b0, mk(1'b1, ftch, st, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
      if (i == TO - 1) begin
        berr_m = 1'b1;
        ok     = 1'b0;
        return;
      end
    end
    step(1'b1, mk(1'b1, ftch, st, ftch, 1'b0, 1'b0, lir, 1'b0));
  endtask

  task automatic exec_instr(input logic [7:0] op, input logic z,
                            input logic n, input logic c);
    bit ok;
    int cls;
    opcode = op;
    zflag  = z;
    nflag  = n;
    cflag  = c;
    access(0, 0, next_w(), ok);
    if (!ok) begin halt_m = 1'b1; return; end
    cls = cls_of(op);
    step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    if (cls == 0) begin
      ill_m = 1'b1;
      if (!sel) halt_m = 1'b1;
      return;
    end
    if (cls == 6) begin halt_m = 1'b1; return; end
    if (cls == 1) begin
      step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0));
      return;
    end
    for (int b = 1; b <= OPND; b++) begin
      access(0, b, next_w(), ok);
      if (!ok) begin halt_m = 1'b1; return; end
    end
    case (cls)
      2: step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0));
      3: begin
        access(1, 0, next_w(), ok);
        if (!ok) begin halt_m = 1'b1; return; end
        step(rnd(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0));
      end
      4: begin
        access(2, 0, next_w(), ok);
        if (!ok) begin halt_m = 1'b1; return; end
      end
      default:
        step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, br_of(op, z, n, c), 1'b0, 3'b000, 1'b0));
    endcase
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1));
  endtask

  // Reset asserted mid-cycle: outputs and flags must drop before the next edge.
  task automatic do_reset();
    rst    = 1'b1;
    ill_m  = 1'b0;
    berr_m = 1'b0;
    halt_m = 1'b0;
    w_plan.delete();
    step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    rst = 1'b0;
    step(rnd(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_exp, mon_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = sel ? vb : va;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outvec t=%0t dut=%s op=%02h got=%b exp=%b",
                 $time, sel ? "b" : "a", opcode, mon_act, mon_exp);
      end
    end
  end

  // ---------------- time bound ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL sim_timeout got=running exp=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] op;
    int         r;
    rst = 1'b1; sel = 1'b0; mem_ready = 1'b0;
    opcode = 8'h00; zflag = 1'b0; nflag = 1'b0; cflag = 1'b0;
    ill_m = 1'b0; berr_m = 1'b0; halt_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    checks++;
    if (a_state !== 4'd1) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=1", a_state);
    end
    checks++;
    if (a_illegal !== 1'b0 || a_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b exp=00", a_illegal, a_bus_err);
    end

    // Zero-wait implied op, then a read op with two wait cycles per access.
    w_plan.push_back(0);
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) w_plan.push_back(2);
    exec_instr(8'h01, 1'b0, 1'b0, 1'b0);
    exec_instr(8'h03, 1'b0, 1'b0, 1'b0);
    exec_instr(8'h0E, 1'b0, 1'b0, 1'b0);

    // Branch sweep over {z,n,c} = 000, 100, 110, 001.
    for (int o = 8'h10; o <= 8'h15; o++) begin
      exec_instr(8'(o), 1'b0, 1'b0, 1'b0);
      exec_instr(8'(o), 1'b1, 1'b0, 1'b0);
      exec_instr(8'(o), 1'b1, 1'b1, 1'b0);
      exec_instr(8'(o), 1'b0, 1'b0, 1'b1);
    end

    // Illegal opcode traps; HALT instruction; both ignore mem_ready.
    exec_instr(8'h20, 1'b0, 1'b0, 1'b0);
    halt_cycles(4);
    checks++;
    if (a_illegal !== 1'b1 || a_halted !== 1'b1) begin
      errors++;
      $display("FAIL trap_flags got=%b%b exp=11", a_illegal, a_halted);
    end
    checks++;
    if (a_state !== 4'd10) begin
      errors++;
      $display("FAIL trap_state got=%0d exp=10", a_state);
    end
    do_reset();
    exec_instr(8'h1F, 1'b0, 1'b0, 1'b0);
    halt_cycles(3);
    checks++;
    if (a_halted !== 1'b1 || a_illegal !== 1'b0) begin
      errors++;
      $display("FAIL halt_op got=%b%b exp=10", a_halted, a_illegal);
    end
    do_reset();

    // Watchdog: timeout exactly at TO waits; ready on the TO-th cycle wins.
    w_plan.push_back(TO);
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0);
    halt_cycles(3);
    checks++;
    if (a_bus_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_bus_err got=%b exp=1", a_bus_err);
    end
    checks++;
    if (a_state !== 4'd10) begin
      errors++;
      $display("FAIL wd_state got=%0d exp=10", a_state);
    end
    do_reset();
    w_plan.push_back(TO - 1);
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (a_bus_err !== 1'b0 || a_state !== 4'd1) begin
      errors++;
      $display("FAIL wd_ready_wins got=%b/%0d exp=0/1", a_bus_err, a_state);
    end
    w_plan.push_back(0); w_plan.push_back(TO + 3);
    exec_instr(8'h02, 1'b0, 1'b0, 1'b0);
    halt_cycles(2);
    do_reset();
    w_plan.push_back(0); w_plan.push_back(0); w_plan.push_back(0);
    w_plan.push_back(TO);
    exec_instr(8'h03, 1'b0, 1'b0, 1'b0);
    halt_cycles(2);
    do_reset();

    // Randomized instruction stream.
    repeat (80) begin
      r = $urandom_range(0, 99);
      if (r < 5) op = 8'h1F;
      else if (r < 10) begin
        op = 8'($urandom_range(8'h16, 8'hFF));
        if (op == 8'h1F) op = 8'h20;
      end else op = 8'($urandom_range(0, 8'h15));
      if (r >= 95) w_plan.push_back(TO + $urandom_range(0, 2));
      exec_instr(op, rnd(), rnd(), rnd());
      if (halt_m) begin
        halt_cycles(2);
        do_reset();
      end
    end

    // Non-trapping instance: illegal is recorded and fetch resumes.
    rst = 1'b1;
    sel = 1'b1;
    do_reset();
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0);
    exec_instr(8'h20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b_illegal !== 1'b1) begin
      errors++;
      $display("FAIL notrap_illegal got=%b exp=1", b_illegal);
    end
    checks++;
    if (b_state !== 4'd1 || b_halted !== 1'b0) begin
      errors++;
      $display("FAIL notrap_resume got=%0d/%b exp=1/0", b_state, b_halted);
    end
    exec_instr(8'h01, 1'b0, 1'b0, 1'b0);
    repeat (15) begin
      r = $urandom_range(0, 99);
      op = (r < 25) ? 8'($urandom_range(8'h20, 8'hFF)) : 8'($urandom_range(0, 8'h15));
      exec_instr(op, rnd(), rnd(), rnd());
      if (halt_m) begin halt_cycles(2); do_reset(); end
    end

    // Reset in the middle of an opcode fetch clears sticky flags.
    opcode = 8'h00;
    step(1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    step(1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    do_reset();
    checks++;
    if (b_state !== 4'd1) begin
      errors++;
      $display("FAIL midreset_state got=%0d exp=1", b_state);
    end
    checks++;
    if (b_illegal !== 1'b0 || b_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags got=%b%b exp=00", b_illegal, b_bus_err);
    end
    exec_instr(8'h00, 1'b0, 1'b0, 1'b0);
    exec_instr(8'h13, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_v2.md
Name: cu_v2

Overview:
- Second-generation control unit for the 8-bit accumulator processor; sequences fetch, decode and execute for the datapath.
- Replaces fixed-delay memory states with a mem_req/mem_ready handshake, with a bus-timeout watchdog.
- Supports multi-byte operands, a carry branch, a HALT instruction and illegal-opcode trapping.
- Sits between the instruction register/PC/accumulator datapath and the memory interface.

Parameters:
- OPND_BYTES, 1, operand bytes fetched after the opcode for classes 2-5; legal range 1..3.
- TIMEOUT, 15, maximum cycles to wait for mem_ready per access; 0 disables the watchdog.
- TRAP_ILLEGAL, 1, 1 = illegal opcode halts; 0 = illegal opcode is skipped and fetch resumes.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  8  instruction register opcode byte; valid from DECODE onward.
- zflag  in  1  accumulator zero flag.
- nflag  in  1  accumulator negative flag.
- cflag  in  1  ALU carry flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access in progress.
- fetch  out  1  address mux select: 1 = PC, 0 = operand address.
- store_mem  out  1  write qualifier for the current access.
- incr_pc  out  1  PC increment pulse.
- load_pc  out  1  PC load pulse (branch taken).
- load_ac  out  1  accumulator load pulse.
- load_ir  out  OPND_BYTES+1  one-hot IR byte load; bit 0 = opcode byte.
- halted  out  1  in HALT state.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous):
  - state=START, byte index=0, timeout counter=0.
  - illegal=0, bus_err=0.
  - All pulse outputs 0, fetch=1.
- Defaults in every state: fetch=1; all other outputs 0 unless listed below.
- States: START, FETCH_OP, DECODE, FETCH_OPND, EXEC_IMPL, EXEC_IMM, EXEC_RD, EXEC_RD_WB, EXEC_ST, EXEC_BR, HALT.
- START -> FETCH_OP unconditionally.
- FETCH_OP:
  - mem_req=1 every cycle.
  - On the cycle mem_ready=1 (Mealy): load_ir[0]=1, incr_pc=1, then -> DECODE.
  - Otherwise stay.
- DECODE: route on opcode class:
  - class 1 (00,04) -> EXEC_IMPL.
  - class 6 (1F) -> HALT.
  - classes 2-5 -> FETCH_OPND with byte index=1.
  - illegal: set illegal=1; go to HALT if TRAP_ILLEGAL, else to FETCH_OP.
- FETCH_OPND:
  - mem_req=1.
  - On mem_ready: load_ir[idx]=1 and incr_pc=1.
  - If idx==OPND_BYTES, go to the class target: 2 -> EXEC_IMM, 3 -> EXEC_RD, 4 -> EXEC_ST, 5 -> EXEC_BR.
  - Otherwise idx+1 and stay.
- Class membership:
  - class 2: 02,06,08,0E,0F.
  - class 3: 01,05,07,09,0A,0B,0C,0D.
  - class 4: 03.
  - class 5: 10-15.
- EXEC_IMPL, EXEC_IMM: load_ac=1 for one cycle, then -> FETCH_OP.
- EXEC_RD: mem_req=1, fetch=0; on mem_ready -> EXEC_RD_WB.
- EXEC_RD_WB: fetch=0, load_ac=1, then -> FETCH_OP.
- EXEC_ST:
  - mem_req=1, fetch=0, store_mem=1 while waiting.
  - On mem_ready -> FETCH_OP; exactly one ready-qualified write occurs.
- EXEC_BR: one cycle, then -> FETCH_OP. load_pc per opcode:
  - 10: 1.
  - 11: nflag.
  - 12: zflag&~nflag.
  - 13: zflag.
  - 14: ~zflag.
  - 15: cflag.
- HALT:
  - halted=1, all pulses 0; remains until reset.
  - mem_ready is ignored.
- Watchdog:
  - Counter clears on entry to any waiting state and increments each cycle mem_ready=0 in that state.
  - When it reaches TIMEOUT while mem_ready=0: bus_err=1 -> HALT.
  - mem_ready on the same cycle as the timeout wins (access completes).
- mem_ready outside waiting states is ignored.
- Reset mid-access drops mem_req asynchronously; no partial IR or AC load.
- Sticky flags clear only on reset.
- Latency with zero-wait memory (mem_ready held 1):
  - class 1: 3 cycles (FETCH_OP, DECODE, EXEC).
  - class 2/5: 3+OPND_BYTES cycles.
  - class 3: 4+OPND_BYTES cycles.
  - class 4: 3+OPND_BYTES cycles.

Decomposition:
- Package cu_v2_pkg holds:
  - state enum (logic [3:0]).
  - opclass enum (IMPL, IMM, RD, ST, BR, HLT, ILL).
  - opcode constants.
  - opclass decode function.
- Sub-module cu_mem_watchdog (param TIMEOUT; inputs clk, rst, clear, wait_en, mem_ready; output expire) isolates the counter.

Test Plan:
- Reset, then opcode 00 with mem_ready=1 -> START, FETCH_OP (load_ir=01, incr_pc), DECODE, EXEC_IMPL (load_ac) -> back in FETCH_OP at cycle 4.
- OPND_BYTES=2, opcode 01, mem_ready low 2 cycles per access -> load_ir pulses 001, 010, 100, each on its ready cycle; fetch=0 in EXEC_RD/WB; load_ac once.
- Opcode 03 -> store_mem=1 with fetch=0 only in EXEC_ST; exactly one ready-qualified write.
- Opcodes 10-15 swept with {z,n,c} = 000, 100, 110, 001 -> load_pc matches the branch table in each case, e.g. 12 with z=1, n=1 gives 0; 15 with c=1 gives 1.
- Opcode 0x20 with TRAP_ILLEGAL=1 -> illegal=1, halted=1 and stays halted; with TRAP_ILLEGAL=0 -> illegal=1 and FETCH_OP resumes next cycle.
- TIMEOUT=4, mem_ready held 0 in FETCH_OP -> bus_err=1 and HALT after 4 wait cycles; a rerun with mem_ready=1 on the 4th cycle gives no error; asserting rst mid-wait clears all state and flags.
